display_readback_monitor: RTL and testbench

- Receive-side counterpart of the scoreboard display path: samples the six active-low seven-segment buses (team A/B tens and units, tento A/B).
- Decodes them back to binary scores and filters out glitches.
- Classifies each settled change as a game event and emits it on a valid/ready interface.
- Used for on-board self-check and for host readback of the truco scoreboard.

---
 rtl/display_readback_monitor.sv | 173 +++++++++++++++++
 tb/tb_display_readback_monitor.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_readback_monitor.sv
// display_readback_monitor
//   Receive-side check of the truco scoreboard display. Samples the six
//   active-low seven-segment buses and waits for each word to settle before
//   trusting it. It then decodes the word back to binary scores and reports
//   every committed change as a classified event on a valid/ready interface.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   seg_a_dez/und        team A tens/units segments (active-low, bit6..0 = g..a)
//   seg_b_dez/und        team B tens/units segments
//   seg_tento_a/b        tento digits, same encoding
//   score_a/b, tento_a/b committed decoded values
//   snapshot_valid       a word has been committed since reset
//   evt_valid/ready/code event stream
//                        (0 INIT, 1 PT_A, 2 PT_B, 3 CLEAR, 4 TENTO, 5 JUMP, 6 RANGE)
//   pattern_err          settled word holds an undecodable digit
//   range_err            last commit was out of range
//   evt_overrun          sticky, an event was dropped while one was pending
//
// Build option
//   BLANK_ZERO_EN: a blank tens digit (1111111) decodes as 0 (leading-zero
//   suppression). Blank is invalid on every other digit in every build.
module display_readback_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_SCORE     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_a_dez,
  input  logic [6:0] seg_a_und,
  input  logic [6:0] seg_b_dez,
  input  logic [6:0] seg_b_und,
  input  logic [6:0] seg_tento_a,
  input  logic [6:0] seg_tento_b,
  output logic [6:0] score_a,
  output logic [6:0] score_b,
  output logic [1:0] tento_a,
  output logic [1:0] tento_b,
  output logic       snapshot_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       pattern_err,
  output logic       range_err,
  output logic       evt_overrun
);

`ifdef BLANK_ZERO_EN
  localparam logic BLANK_DEZ = 1'b1;
`else
  localparam logic BLANK_DEZ = 1'b0;
`endif

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  // returns {valid, value}
  function automatic logic [4:0] seg_decode(input logic [6:0] s, input logic blank_ok);
    case (s)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      7'b1111111: return {blank_ok, 4'd0};
      default:    return 5'd0;
    endcase
  endfunction

  logic [41:0] word_in;
  logic [41:0] sample_q, cand_q, comm_q;
  logic [3:0]  cnt_q;
  logic        have_commit_q;

  logic [4:0]  d_ad, d_au, d_bd, d_bu, d_ta, d_tb;
  logic [6:0]  new_a, new_b;
  logic        all_valid, settled, commit, range_hit;
  logic [2:0]  code_nxt;

  assign word_in = {seg_a_dez, seg_a_und, seg_b_dez, seg_b_und, seg_tento_a, seg_tento_b};

  always_comb begin
    d_ad = seg_decode(cand_q[41:35], BLANK_DEZ);
    d_au = seg_decode(cand_q[34:28], 1'b0);
    d_bd = seg_decode(cand_q[27:21], BLANK_DEZ);
    d_bu = seg_decode(cand_q[20:14], 1'b0);
    d_ta = seg_decode(cand_q[13:7],  1'b0);
    d_tb = seg_decode(cand_q[6:0],   1'b0);
    all_valid = d_ad[4] & d_au[4] & d_bd[4] & d_bu[4] & d_ta[4] & d_tb[4];
    new_a = 7'(d_ad[3:0]) * 7'd10 + 7'(d_au[3:0]);
    new_b = 7'(d_bd[3:0]) * 7'd10 + 7'(d_bu[3:0]);
    // The first word after reset must commit even if it equals the (cleared)
    // committed register contents.
    settled   = (cnt_q == CNT_MAX) && ((cand_q != comm_q) || !have_commit_q);
    commit    = settled && all_valid;
    range_hit = (new_a > 7'(MAX_SCORE)) || (new_b > 7'(MAX_SCORE)) ||
                (d_ta[3:0] > 4'd3) || (d_tb[3:0] > 4'd3);

    code_nxt = 3'd5;
    if (range_hit)
      code_nxt = 3'd6;
    else if (!have_commit_q)
      code_nxt = 3'd0;
    else if (new_a == 7'd0 && new_b == 7'd0 && (score_a != 7'd0 || score_b != 7'd0))
      code_nxt = 3'd3;
    else if (new_a == score_a + 7'd1 && new_b == score_b)
      code_nxt = 3'd1;
    else if (new_b == score_b + 7'd1 && new_a == score_a)
      code_nxt = 3'd2;
    // Tento patterns map one-to-one onto values, so comparing the raw segment
    // bits is exact and also catches changes hidden by the 2-bit outputs.
    else if (new_a == score_a && new_b == score_b && cand_q[13:0] != comm_q[13:0])
      code_nxt = 3'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q       <= '0;
      cand_q         <= '0;
      comm_q         <= '0;
      cnt_q          <= '0;
      have_commit_q  <= 1'b0;
      score_a        <= '0;
      score_b        <= '0;
      tento_a        <= '0;
      tento_b        <= '0;
      snapshot_valid <= 1'b0;
      evt_valid      <= 1'b0;
      evt_code       <= '0;
      pattern_err    <= 1'b0;
      range_err      <= 1'b0;
      evt_overrun    <= 1'b0;
    end else begin
      sample_q <= word_in;

      if (settled && !all_valid)
        pattern_err <= 1'b1;

      if (sample_q != cand_q) begin
        cand_q      <= sample_q;
        cnt_q       <= 4'd1;
        pattern_err <= 1'b0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 4'd1;
      end

      if (commit) begin
        comm_q         <= cand_q;
        have_commit_q  <= 1'b1;
        score_a        <= new_a;
        score_b        <= new_b;
        tento_a        <= d_ta[1:0];
        tento_b        <= d_tb[1:0];
        snapshot_valid <= 1'b1;
        pattern_err    <= 1'b0;
        range_err      <= range_hit;
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= code_nxt;
        end else begin
          evt_overrun <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_readback_monitor.sv
module tb_display_readback_monitor;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_a_dez, seg_a_und, seg_b_dez, seg_b_und, seg_tento_a, seg_tento_b;
  logic [6:0] score_a, score_b;
  logic [1:0] tento_a, tento_b;
  logic       snapshot_valid, evt_valid, evt_ready, pattern_err, range_err, evt_overrun;
  logic [2:0] evt_code;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] code;
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  display_readback_monitor #(.STABLE_CYCLES(S), .MAX_SCORE(12)) dut (
    .clk(clk), .rst(rst),
    .seg_a_dez(seg_a_dez), .seg_a_und(seg_a_und),
    .seg_b_dez(seg_b_dez), .seg_b_und(seg_b_und),
    .seg_tento_a(seg_tento_a), .seg_tento_b(seg_tento_b),
    .score_a(score_a), .score_b(score_b),
    .tento_a(tento_a), .tento_b(tento_b),
    .snapshot_valid(snapshot_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .pattern_err(pattern_err), .range_err(range_err), .evt_overrun(evt_overrun)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  task automatic set_word(input int ad, au, bd, bu, ta, tbv);
    seg_a_dez = seg(ad); seg_a_und = seg(au);
    seg_b_dez = seg(bd); seg_b_und = seg(bu);
    seg_tento_a = seg(ta); seg_tento_b = seg(tbv);
  endtask

  task automatic drive(input int ad, au, bd, bu, ta, tbv);
    @(negedge clk);
    set_word(ad, au, bd, bu, ta, tbv);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (evt_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk); evt_ready = 1'b1;
    @(posedge clk); #1; evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; evt_ready = 1'b0;
    set_word(10, 10, 10, 10, 10, 10);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({score_a, score_b, tento_a, tento_b, snapshot_valid, evt_valid, evt_code,
         pattern_err, range_err, evt_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%0d b=%0d ta=%0d tb=%0d snap=%b v=%b code=%0d perr=%b rerr=%b ovr=%b, want all 0",
               score_a, score_b, tento_a, tento_b, snapshot_valid, evt_valid, evt_code,
               pattern_err, range_err, evt_overrun);
    end
  endtask

  task automatic test_init_latency();
    exp_t e;
    bit early = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_word(0, 0, 0, 0, 0, 0);
    exp_q.push_back('{3'd0, 7'd0, 7'd0});
    for (int i = 1; i <= S + 1; i++) begin
      @(posedge clk); #1;
      if (evt_valid !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL init_early: evt_valid=1 before edge %0d, want 0", S + 2);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== e.code || score_a !== e.a || score_b !== e.b ||
        snapshot_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL init_event: v=%b code=%0d a=%0d b=%0d snap=%b, want v=1 code=%0d a=%0d b=%0d snap=1",
               evt_valid, evt_code, score_a, score_b, snapshot_valid, e.code, e.a, e.b);
    end
    accept();
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_accept: evt_valid=%b, want 0", evt_valid);
    end
  endtask

  task automatic test_point_a();
    exp_t e;
    bit ok;
    bit bad = 1'b0;
    drive(0, 3, 0, 0, 0, 0);
    exp_q.push_back('{3'd5, 7'd3, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || score_b !== e.b) begin
      n_fail++;
      $display("FAIL jump_to_3: ok=%b code=%0d a=%0d b=%0d, want code=%0d a=%0d b=%0d",
               ok, evt_code, score_a, score_b, e.code, e.a, e.b);
    end
    accept();
    drive(0, 4, 0, 0, 0, 0);
    exp_q.push_back('{3'd1, 7'd4, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || score_b !== e.b) begin
      n_fail++;
      $display("FAIL pt_a: ok=%b code=%0d a=%0d b=%0d, want code=%0d a=%0d b=%0d",
               ok, evt_code, score_a, score_b, e.code, e.a, e.b);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (evt_valid !== 1'b1 || evt_code !== e.code) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL pt_a_hold: v=%b code=%0d, want held v=1 code=%0d", evt_valid, evt_code, e.code);
    end
    accept();
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pt_a_accept: evt_valid=%b, want 0", evt_valid);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk); seg_b_und = seg(7);
    repeat (S - 1) @(posedge clk);
    @(negedge clk); seg_b_und = seg(0);
    repeat (2 * S + 6) @(posedge clk);
    #1;
    n_tests++;
    if (evt_valid !== 1'b0 || score_a !== 7'd4 || score_b !== 7'd0 || pattern_err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch: v=%b a=%0d b=%0d perr=%b, want v=0 a=4 b=0 perr=0",
               evt_valid, score_a, score_b, pattern_err);
    end
  endtask

  task automatic test_pattern_err();
    exp_t e;
    bit ok;
    @(negedge clk); seg_b_und = 7'b0101010;
    repeat (S + 3) @(posedge clk);
    #1;
    n_tests++;
    if (pattern_err !== 1'b1 || evt_valid !== 1'b0 || score_b !== 7'd0) begin
      n_fail++;
      $display("FAIL pattern_set: perr=%b v=%b b=%0d, want perr=1 v=0 b=0", pattern_err, evt_valid, score_b);
    end
    @(negedge clk); seg_b_und = seg(2);
    exp_q.push_back('{3'd5, 7'd4, 7'd2});
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (pattern_err !== 1'b0) begin
      n_fail++;
      $display("FAIL pattern_clear: perr=%b, want 0", pattern_err);
    end
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || score_b !== e.b) begin
      n_fail++;
      $display("FAIL pattern_commit: ok=%b code=%0d a=%0d b=%0d, want code=%0d a=%0d b=%0d",
               ok, evt_code, score_a, score_b, e.code, e.a, e.b);
    end
    accept();
  endtask

  task automatic test_overrun();
    exp_t e;
    bit ok;
    drive(0, 5, 0, 2, 0, 0);
    exp_q.push_back('{3'd1, 7'd5, 7'd2});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || score_b !== e.b) begin
      n_fail++;
      $display("FAIL a_5: ok=%b code=%0d a=%0d b=%0d, want code=%0d a=%0d b=%0d",
               ok, evt_code, score_a, score_b, e.code, e.a, e.b);
    end
    accept();
    drive(0, 6, 0, 2, 0, 0);
    exp_q.push_back('{3'd1, 7'd6, 7'd2});
    wait_valid(3 * S + 10, ok);
    drive(0, 6, 0, 3, 0, 0);
    repeat (S + 4) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_valid !== 1'b1 || evt_code !== e.code || score_a !== 7'd6 ||
        score_b !== 7'd3 || evt_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun: ok=%b v=%b code=%0d a=%0d b=%0d ovr=%b, want v=1 code=%0d a=6 b=3 ovr=1",
               ok, evt_valid, evt_code, score_a, score_b, evt_overrun, e.code);
    end
    @(negedge clk);
    rst = 1'b1;
    set_word(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    exp_q.delete();
    n_tests++;
    if ({score_a, score_b, tento_a, tento_b, snapshot_valid, evt_valid, evt_code,
         pattern_err, range_err, evt_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: a=%0d b=%0d snap=%b v=%b code=%0d perr=%b rerr=%b ovr=%b, want all 0",
               score_a, score_b, snapshot_valid, evt_valid, evt_code, pattern_err, range_err, evt_overrun);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    exp_q.push_back('{3'd0, 7'd0, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || score_b !== e.b) begin
      n_fail++;
      $display("FAIL reinit: ok=%b code=%0d a=%0d b=%0d, want code=%0d a=%0d b=%0d",
               ok, evt_code, score_a, score_b, e.code, e.a, e.b);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    drive(0, 1, 0, 0, 0, 0);
    exp_q.push_back('{3'd1, 7'd1, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a) begin
      n_fail++;
      $display("FAIL b2b_first: ok=%b code=%0d a=%0d, want code=%0d a=%0d", ok, evt_code, score_a, e.code, e.a);
    end
    @(negedge clk); seg_a_und = seg(2);
    exp_q.push_back('{3'd1, 7'd2, 7'd0});
    repeat (S + 1) @(posedge clk);
    @(negedge clk); evt_ready = 1'b1;
    @(posedge clk); #1; evt_ready = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== e.code || score_a !== e.a || evt_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b code=%0d a=%0d ovr=%b, want v=1 code=%0d a=%0d ovr=0",
               evt_valid, evt_code, score_a, evt_overrun, e.code, e.a);
    end
    accept();
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: evt_valid=%b, want 0", evt_valid);
    end
  endtask

  task automatic test_range_and_classes();
    exp_t e;
    bit ok;
    drive(1, 3, 0, 0, 0, 0);
    exp_q.push_back('{3'd6, 7'd13, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL range_13: ok=%b code=%0d a=%0d rerr=%b, want code=%0d a=%0d rerr=1",
               ok, evt_code, score_a, range_err, e.code, e.a);
    end
    accept();
    @(negedge clk); seg_a_dez = 7'b1111111; seg_a_und = seg(5);
`ifdef BLANK_ZERO_EN
    exp_q.push_back('{3'd5, 7'd5, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_zero: ok=%b code=%0d a=%0d rerr=%b, want code=%0d a=%0d rerr=0",
               ok, evt_code, score_a, range_err, e.code, e.a);
    end
    accept();
`else
    repeat (S + 3) @(posedge clk);
    #1;
    n_tests++;
    if (pattern_err !== 1'b1 || evt_valid !== 1'b0 || score_a !== 7'd13) begin
      n_fail++;
      $display("FAIL blank_invalid: perr=%b v=%b a=%0d, want perr=1 v=0 a=13", pattern_err, evt_valid, score_a);
    end
`endif
    drive(0, 5, 0, 0, 0, 0);
    exp_q.push_back('{3'd5, 7'd5, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || range_err !== 1'b0 || pattern_err !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_5: ok=%b code=%0d a=%0d rerr=%b perr=%b, want code=%0d a=%0d rerr=0 perr=0",
               ok, evt_code, score_a, range_err, pattern_err, e.code, e.a);
    end
    accept();
    drive(0, 5, 0, 0, 2, 0);
    exp_q.push_back('{3'd4, 7'd5, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || tento_a !== 2'd2) begin
      n_fail++;
      $display("FAIL tento: ok=%b code=%0d a=%0d ta=%0d, want code=%0d a=%0d ta=2",
               ok, evt_code, score_a, tento_a, e.code, e.a);
    end
    accept();
    drive(0, 0, 0, 0, 0, 0);
    exp_q.push_back('{3'd3, 7'd0, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || score_a !== e.a || score_b !== e.b || tento_a !== 2'd0) begin
      n_fail++;
      $display("FAIL clear: ok=%b code=%0d a=%0d b=%0d ta=%0d, want code=%0d a=0 b=0 ta=0",
               ok, evt_code, score_a, score_b, tento_a, e.code);
    end
    accept();
    drive(0, 0, 0, 0, 0, 5);
    exp_q.push_back('{3'd6, 7'd0, 7'd0});
    wait_valid(3 * S + 10, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || evt_code !== e.code || range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tento_range: ok=%b code=%0d rerr=%b, want code=%0d rerr=1", ok, evt_code, range_err, e.code);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_init_latency();
    test_point_a();
    test_glitch();
    test_pattern_err();
    test_overrun();
    test_back_to_back();
    test_range_and_classes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
